// File: rtl/imem_if.sv
// imem_if: word-addressed combinational instruction-memory bus between fetch and memory.
interface imem_if #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
);
   logic [AWIDTH-1:0] addr;
   logic [DWIDTH-1:0] dout;
   modport master (output addr, input dout);
   modport slave (input addr, output dout);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, instruction-memory addressing and IF/ID capture with stall and flush-on-redirect.
module fetch_unit #(
   parameter int AWIDTH = 32,
   parameter int IMEM_ABITS = 9,
   parameter int DWIDTH = 32,
   parameter logic [AWIDTH-1:0] RESET_PC = '0,
   parameter logic [DWIDTH-1:0] NOP = '0
) (
   input  logic              clk,
   input  logic              reset,
   imem_if.master            imem,
   input  logic              stall,
   input  logic              br_taken,
   input  logic [AWIDTH-1:0] br_target,
   input  logic              jump,
   input  logic [AWIDTH-1:0] jump_target,
   input  logic              jr,
   input  logic [AWIDTH-1:0] jr_target,
   output logic [AWIDTH-1:0] pc,
   output logic [DWIDTH-1:0] if_instr,
   output logic [AWIDTH-1:0] if_pc4,
   output logic              if_valid,
   output logic [31:0]       fetch_count
);
   logic              redirect;
   logic [AWIDTH-1:0] target;
   logic [AWIDTH-1:0] pc4;
   always_comb begin
      redirect = jr | jump | br_taken;
      target   = (jr ? jr_target : jump ? jump_target : br_target) & ~AWIDTH'(3);
      pc4      = pc + AWIDTH'(4);
   end
   // Upper address bits forced low so memory aliases every 2^IMEM_ABITS words.
   assign imem.addr = AWIDTH'(pc[IMEM_ABITS+1:2]);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         if_instr    <= NOP;
         if_pc4      <= '0;
         if_valid    <= 1'b0;
         fetch_count <= '0;
      end else if (redirect) begin
         pc       <= target;
         if_instr <= NOP;
         if_pc4   <= '0;
         if_valid <= 1'b0;
      end else if (!stall) begin
         pc          <= pc4;
         if_instr    <= imem.dout;
         if_pc4      <= pc4;
         if_valid    <= 1'b1;
         fetch_count <= fetch_count + 32'd1;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch, stall, redirect priority, address wrap and async reset.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0, br_taken = 1'b0, jump = 1'b0, jr = 1'b0;
   logic [31:0] br_target = '0, jump_target = '0, jr_target = '0;
   logic [31:0] pc, if_pc4, fetch_count, if_instr;
   logic        if_valid;
   logic [31:0] pc2, if_pc42, fetch_count2, if_instr2;
   logic        if_valid2;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   imem_if #(.AWIDTH(32), .DWIDTH(32)) ibus ();
   imem_if #(.AWIDTH(32), .DWIDTH(32)) ibus2 ();
   assign ibus.dout  = 32'h1000_0000 + ibus.addr;
   assign ibus2.dout = 32'h1000_0000 + ibus2.addr;

   fetch_unit dut (
      .clk(clk), .reset(reset), .imem(ibus.master), .stall(stall),
      .br_taken(br_taken), .br_target(br_target), .jump(jump), .jump_target(jump_target),
      .jr(jr), .jr_target(jr_target), .pc(pc), .if_instr(if_instr), .if_pc4(if_pc4),
      .if_valid(if_valid), .fetch_count(fetch_count)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .reset(reset), .imem(ibus2.master), .stall(1'b0),
      .br_taken(1'b0), .br_target(32'h0), .jump(1'b0), .jump_target(32'h0),
      .jr(1'b0), .jr_target(32'h0), .pc(pc2), .if_instr(if_instr2), .if_pc4(if_pc42),
      .if_valid(if_valid2), .fetch_count(fetch_count2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      reset = 1'b0;
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
      n_checks++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want %h", if_instr, 32'h0); end
      n_checks++; if (if_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got %h want %h", if_pc4, 32'h0); end
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", if_valid); end
      n_checks++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fetch_count); end
      n_checks++; if (pc2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL reset_pc_alt got %h want %h", pc2, 32'hFFFF_FFFC); end
   endtask

   task automatic test_reset_pc_wrap();
      tick();
      n_checks++; if (pc2 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h want 0", pc2); end
      n_checks++; if (if_pc42 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got %h want 0", if_pc42); end
      n_checks++; if (if_valid2 !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got %b want 1", if_valid2); end
      n_checks++; if (if_instr2 !== 32'h1000_01FF) begin n_fail++; $display("FAIL wrap_instr got %h want %h", if_instr2, 32'h1000_01FF); end
   endtask

   task automatic test_free_run();
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         tick();
         n_checks++; if (pc !== 32'(4 * k)) begin n_fail++; $display("FAIL run_pc[%0d] got %h want %h", k, pc, 4 * k); end
         n_checks++; if (if_instr !== 32'h1000_0000 + 32'(k - 1)) begin n_fail++; $display("FAIL run_instr[%0d] got %h want %h", k, if_instr, 32'h1000_0000 + 32'(k - 1)); end
         n_checks++; if (if_pc4 !== 32'(4 * k)) begin n_fail++; $display("FAIL run_pc4[%0d] got %h want %h", k, if_pc4, 4 * k); end
         n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL run_valid[%0d] got %b want 1", k, if_valid); end
         n_checks++; if (fetch_count !== 32'(k)) begin n_fail++; $display("FAIL run_count[%0d] got %0d want %0d", k, fetch_count, k); end
      end
   endtask

   task automatic test_stall();
      do_reset();
      tick();
      tick();
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL stall_pc[%0d] got %h want 8", k, pc); end
         n_checks++; if (if_instr !== 32'h1000_0001) begin n_fail++; $display("FAIL stall_instr[%0d] got %h want %h", k, if_instr, 32'h1000_0001); end
         n_checks++; if (if_pc4 !== 32'h8) begin n_fail++; $display("FAIL stall_pc4[%0d] got %h want 8", k, if_pc4); end
         n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b want 1", k, if_valid); end
         n_checks++; if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL stall_count[%0d] got %0d want 2", k, fetch_count); end
      end
      stall = 1'b0;
      tick();
      n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL resume_pc got %h want c", pc); end
      n_checks++; if (if_instr !== 32'h1000_0002) begin n_fail++; $display("FAIL resume_instr got %h want %h", if_instr, 32'h1000_0002); end
      n_checks++; if (if_pc4 !== 32'hC) begin n_fail++; $display("FAIL resume_pc4 got %h want c", if_pc4); end
      n_checks++; if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL resume_count got %0d want 3", fetch_count); end
   endtask

   task automatic test_redirect_priority();
      jr = 1'b1; jr_target = 32'h40;
      jump = 1'b1; jump_target = 32'h80;
      br_taken = 1'b1; br_target = 32'hC0;
      stall = 1'b1;
      tick();
      {jr, jump, br_taken, stall} = 4'b0;
      n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL redir_pc got %h want 40", pc); end
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid got %b want 0", if_valid); end
      n_checks++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL redir_instr got %h want 0", if_instr); end
      n_checks++; if (if_pc4 !== 32'h0) begin n_fail++; $display("FAIL redir_pc4 got %h want 0", if_pc4); end
      n_checks++; if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL redir_count got %0d want 3", fetch_count); end
      tick();
      n_checks++; if (if_instr !== 32'h1000_0010) begin n_fail++; $display("FAIL after_redir_instr got %h want %h", if_instr, 32'h1000_0010); end
      n_checks++; if (if_pc4 !== 32'h44) begin n_fail++; $display("FAIL after_redir_pc4 got %h want 44", if_pc4); end
      n_checks++; if (fetch_count !== 32'd4) begin n_fail++; $display("FAIL after_redir_count got %0d want 4", fetch_count); end
      jump = 1'b1; jump_target = 32'h200;
      tick();
      jump = 1'b0;
      n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL jump_pc got %h want 200", pc); end
      jump = 1'b1; jump_target = 32'h300; br_taken = 1'b1; br_target = 32'h400;
      tick();
      {jump, br_taken} = 2'b0;
      n_checks++; if (pc !== 32'h300) begin n_fail++; $display("FAIL jump_over_br_pc got %h want 300", pc); end
   endtask

   task automatic test_align_wrap();
      br_taken = 1'b1; br_target = 32'h0000_0107;
      tick();
      br_taken = 1'b0;
      n_checks++; if (pc !== 32'h104) begin n_fail++; $display("FAIL align_pc got %h want 104", pc); end
      n_checks++; if (ibus.addr !== 32'h41) begin n_fail++; $display("FAIL align_addr got %h want 41", ibus.addr); end
      jump = 1'b1; jump_target = 32'h7FC;
      tick();
      jump = 1'b0;
      n_checks++; if (ibus.addr !== 32'h1FF) begin n_fail++; $display("FAIL top_addr got %h want 1ff", ibus.addr); end
      tick();
      n_checks++; if (pc !== 32'h800) begin n_fail++; $display("FAIL wrap_pc800 got %h want 800", pc); end
      n_checks++; if (ibus.addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr got %h want 0", ibus.addr); end
      n_checks++; if (if_instr !== 32'h1000_01FF) begin n_fail++; $display("FAIL top_instr got %h want %h", if_instr, 32'h1000_01FF); end
      n_checks++; if (fetch_count !== 32'd5) begin n_fail++; $display("FAIL align_count got %0d want 5", fetch_count); end
   endtask

   task automatic test_async_reset();
      jr = 1'b1; jr_target = 32'h40;
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL areset_pc got %h want 0", pc); end
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b want 0", if_valid); end
      n_checks++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL areset_instr got %h want 0", if_instr); end
      n_checks++; if (if_pc4 !== 32'h0) begin n_fail++; $display("FAIL areset_pc4 got %h want 0", if_pc4); end
      n_checks++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL areset_count got %0d want 0", fetch_count); end
      #1;
      reset = 1'b0;
      jr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_reset_pc_wrap();
      test_free_run();
      test_stall();
      test_redirect_priority();
      test_align_wrap();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. Holds the program counter and drives the word address into the combinational instruction memory.
- Captures the returned instruction word into an IF/ID pipeline register for the decode stage.
- Handles sequential fetch, stall, and redirect (branch, jump, jump-register) with flush of the fetched slot.

Parameters:
- AWIDTH, 32, width of PC and of the address bus to instruction memory.
- IMEM_ABITS, 9, number of word-address bits actually used by instruction memory.
- DWIDTH, 32, instruction word width.
- RESET_PC, 32'h0000_0000, PC value after reset (byte address, word aligned).
- NOP, 32'h0000_0000, instruction word inserted on flush.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  AWIDTH  word address to instruction memory.
- imem_dout  input  DWIDTH  instruction word from memory (combinational from imem_addr).
- stall  input  1  hold PC and IF/ID register (hazard from decode).
- br_taken  input  1  conditional branch resolved taken.
- br_target  input  AWIDTH  branch target byte address.
- jump  input  1  absolute jump (j/jal).
- jump_target  input  AWIDTH  jump target byte address.
- jr  input  1  register-indirect jump.
- jr_target  input  AWIDTH  register value (byte address).
- pc  output  AWIDTH  current PC (byte address).
- if_instr  output  DWIDTH  IF/ID instruction.
- if_pc4  output  AWIDTH  IF/ID PC+4 of the captured instruction.
- if_valid  output  1  IF/ID slot holds a real instruction.
- fetch_count  output  32  number of valid instructions captured since reset.

Behaviour:
- Reset (async, any time, including mid-redirect): pc=RESET_PC, if_instr=NOP, if_pc4=0, if_valid=0, fetch_count=0. First capture happens on the first rising edge after reset deasserts.
- imem_addr is combinational: {zeros, pc[IMEM_ABITS+1:2]}; upper bits are forced to 0 so memory wraps every 2^IMEM_ABITS words; pc[1:0] is ignored.
- Redirect select, priority jr > jump > br_taken. redirect = jr|jump|br_taken. Target is the selected target with bits [1:0] forced to 00.
- Per rising edge, first matching case wins:
  1. redirect (regardless of stall): pc <= target; if_instr <= NOP; if_pc4 <= 0; if_valid <= 0; fetch_count unchanged. The instruction at the old pc is discarded.
  2. stall, no redirect: pc, if_instr, if_pc4, if_valid, fetch_count all hold.
  3. otherwise: pc <= pc+4; if_instr <= imem_dout; if_pc4 <= pc+4; if_valid <= 1; fetch_count <= fetch_count+1.
- Arithmetic: pc+4 is modulo 2^AWIDTH (32'hFFFF_FFFC -> 0). fetch_count wraps modulo 2^32.
- Latency: an instruction at address A appears on if_instr one cycle after pc==A, provided there is no stall or redirect in that cycle.
- No combinational path from any input to if_* or fetch_count. imem_addr depends only on pc.

Test Plan:
- Reset then 4 free-run cycles, memory word k = 32'h1000_0000+k -> pc goes 0,4,8,12,16; if_instr 32'h1000_0000..1000_0003; if_pc4 4..16; fetch_count=4.
- stall high 3 cycles at pc=8 -> pc, if_instr, if_pc4, if_valid, fetch_count frozen for 3 cycles; sequential fetch resumes from 8 after release.
- Simultaneous jr(target 32'h40), jump(32'h80), br_taken(32'hC0) asserted with stall=1 -> next pc=32'h40, if_valid=0, if_instr=NOP, fetch_count unchanged; the following cycle captures word 16.
- br_target=32'h0000_0107 -> pc=32'h104 and imem_addr=32'h41. Then pc=32'h7FC with IMEM_ABITS=9 -> imem_addr=32'h1FF; next pc=32'h800 -> imem_addr=0.
- RESET_PC=32'hFFFF_FFFC, one free cycle -> pc=0, if_pc4=0, if_valid=1.
- reset pulsed asynchronously between edges during a redirect cycle -> outputs reach reset values immediately, without waiting for clk.
